// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants for the stopwatch sequencer: state encodings and STATE width.
// Reused by the display mux and benches.
package stopwatch_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    // RUN and LAP both keep the prescaler moving; LAP only freezes the display.
    function automatic logic is_counting(sw_state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-sample debounce,
// and a one-cycle registered pulse on each accepted press (releases are silent).
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_accept;

    // The DB_CYCLES-th consecutive disagreeing sample flips the level.
    assign w_differ = r_sync2 ^ r_db;
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_pulse <= w_accept && r_sync2;
            if (w_accept) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced START_STOP / LAP_RESET drive a four-state FSM
// that generates TICK, CLR and HOLD for the centisecond counter chain.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 10,
    parameter int DB_CYCLES   = 4,
    parameter bit STOP_AT_MAX = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START_STOP,
    input  logic               LAP_RESET,
    input  logic               AT_MAX,
    output logic               TICK,
    output logic               CLR,
    output logic               HOLD,
    output logic [STATE_W-1:0] STATE
);

    localparam int            PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    sw_state_e     r_state;
    sw_state_e     w_next;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          r_tick;
    logic          r_clr;
    logic          r_hold;
    logic          w_ss_p;
    logic          w_lr_p;
    logic          w_active;
    logic          w_term;
    logic          w_max_stop;
    logic          w_tick;
    logic          w_clr;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_btn   (START_STOP),
        .o_pulse (w_ss_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lr (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_btn   (LAP_RESET),
        .o_pulse (w_lr_p)
    );

    // A terminal prescaler count with the chain at 99 pauses instead of ticking.
    assign w_active   = is_counting(r_state);
    assign w_term     = w_active && (r_presc == P_LAST);
    assign w_max_stop = STOP_AT_MAX && w_term && AT_MAX;
    assign w_tick     = w_term && !w_max_stop;

    always_comb begin
        w_presc_next = r_presc;
        if (w_active) begin
            w_presc_next = w_term ? '0 : r_presc + PW'(1);
        end else if (r_state == ST_IDLE) begin
            w_presc_next = '0;
        end
    end

    // START_STOP has priority whenever both pulses land in the same cycle.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_p)      w_next = ST_RUN;
                else if (w_lr_p) w_clr  = 1'b1;
            end
            ST_RUN: begin
                if (w_max_stop || w_ss_p) w_next = ST_PAUSE;
                else if (w_lr_p)          w_next = ST_LAP;
            end
            ST_LAP: begin
                if (w_max_stop || w_ss_p) w_next = ST_PAUSE;
                else if (w_lr_p)          w_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (w_ss_p) begin
                    w_next = ST_RUN;
                end else if (w_lr_p) begin
                    w_next = ST_IDLE;
                    w_clr  = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_clr   <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_presc <= w_presc_next;
            r_tick  <= w_tick;
            r_clr   <= w_clr;
            r_hold  <= (w_next == ST_LAP);
        end
    end

    assign TICK  = r_tick;
    assign CLR   = r_clr;
    assign HOLD  = r_hold;
    assign STATE = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (halt-at-99 and wrap) share the buttons,
// each checked every cycle against a behavioural model plus directed timing checks.
module tb_stopwatch_ctrl;
    import stopwatch_ctrl_pkg::*;

    localparam int TD = 10;
    localparam int DB = 4;
    localparam int PL = DB + 5;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       ss  = 1'b0;
    logic       lr  = 1'b0;
    logic       force_max = 1'b0;
    logic [1:0] st[2];
    logic       tick[2];
    logic       clr[2];
    logic       hold[2];
    logic       amax[2];
    int         cnt_vis[2] = '{0, 0};
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    // Model state: index 0 halts at 99, index 1 wraps.
    logic [1:0] m_st[2];
    int         m_ph[2];
    int         m_cnt[2];
    logic       m_tick[2];
    logic       m_clr[2];
    logic       hist[2][2];
    logic       win[2][DB];
    int         nwin[2];
    logic       db[2];
    logic       pl[2];

    assign amax[0] = force_max | (cnt_vis[0] == 99);
    assign amax[1] = force_max | (cnt_vis[1] == 99);

    always #5 CLK = ~CLK;

    stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB), .STOP_AT_MAX(1'b1)) u_stop (
        .CLK(CLK), .RST(RST), .START_STOP(ss), .LAP_RESET(lr), .AT_MAX(amax[0]),
        .TICK(tick[0]), .CLR(clr[0]), .HOLD(hold[0]), .STATE(st[0])
    );

    stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB), .STOP_AT_MAX(1'b0)) u_wrap (
        .CLK(CLK), .RST(RST), .START_STOP(ss), .LAP_RESET(lr), .AT_MAX(amax[1]),
        .TICK(tick[1]), .CLR(clr[1]), .HOLD(hold[1]), .STATE(st[1])
    );

    function automatic logic [4:0] obs(int i);
        return {st[i], tick[i], clr[i], hold[i]};
    endfunction

    function automatic logic [4:0] expv(int i);
        return {m_st[i], m_tick[i], m_clr[i], (m_st[i] == 2'd3)};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 2'd0; m_ph[i] = 0; m_cnt[i] = 0; m_tick[i] = 1'b0; m_clr[i] = 1'b0;
            hist[i][0] = 1'b0; hist[i][1] = 1'b0; nwin[i] = 0; db[i] = 1'b0; pl[i] = 1'b0;
        end
    endtask

    task automatic m_step();
        logic act, term, stopm, sp, lp, syn, all_diff, raw;
        sp = pl[0];
        lp = pl[1];
        for (int i = 0; i < 2; i++) begin
            if (m_tick[i]) m_cnt[i] = (m_cnt[i] + 1) % 100;
            if (m_clr[i])  m_cnt[i] = 0;
            act   = (m_st[i] == 2'd1) || (m_st[i] == 2'd3);
            term  = act && (m_ph[i] == TD - 1);
            stopm = term && (i == 0) && amax[i];
            m_tick[i] = term && !stopm;
            m_clr[i]  = 1'b0;
            if (act) m_ph[i] = (m_ph[i] + 1) % TD;
            else if (m_st[i] == 2'd0) m_ph[i] = 0;
            case (m_st[i])
                2'd0: if (sp) m_st[i] = 2'd1; else if (lp) m_clr[i] = 1'b1;
                2'd1: if (stopm || sp) m_st[i] = 2'd2; else if (lp) m_st[i] = 2'd3;
                2'd3: if (stopm || sp) m_st[i] = 2'd2; else if (lp) m_st[i] = 2'd1;
                default: if (sp) m_st[i] = 2'd1;
                         else if (lp) begin m_st[i] = 2'd0; m_clr[i] = 1'b1; end
            endcase
        end
        // Buttons: level flips once the last DB synchronized samples all disagree.
        for (int b = 0; b < 2; b++) begin
            raw = (b == 0) ? ss : lr;
            syn = hist[b][1];
            for (int k = DB - 1; k > 0; k--) win[b][k] = win[b][k-1];
            win[b][0] = syn;
            if (nwin[b] < DB) nwin[b]++;
            all_diff = (nwin[b] == DB);
            for (int k = 0; k < DB; k++) if (win[b][k] == db[b]) all_diff = 1'b0;
            pl[b] = 1'b0;
            if (all_diff) begin
                db[b] = !db[b];
                pl[b] = db[b];
            end
            hist[b][1] = hist[b][0];
            hist[b][0] = raw;
        end
    endtask

    always @(posedge CLK or negedge RST) begin
        if (!RST) m_reset();
        else begin
            m_step();
            cyc++;
        end
    end

    always @(negedge CLK) begin
        cnt_vis[0] = m_cnt[0];
        cnt_vis[1] = m_cnt[1];
    end

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %b want 00000", i, obs(i));
            end
        end
        RST = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL reset_release[%0d] c=%0d: got %b want %b", i, c, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_start_run();
        int lat = -1;
        int last = -1;
        int nt = 0;
        ss = 1'b1;
        for (int c = 1; c <= 1053; c++) begin
            @(negedge CLK);
            if (c == DB + 6) ss = 1'b0;
            if (lat < 0 && st[1] == 2'd1) lat = c;
            if (tick[1]) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last != TD) begin
                        n_fail++;
                        $display("FAIL tick_period: got %0d want %0d", c - last, TD);
                    end
                end
                last = c;
                nt++;
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL start_run[%0d] c=%0d: got %b want %b", i, c, obs(i), expv(i));
                end
            end
        end
        n_cmp++;
        if (lat != DB + 3) begin
            n_fail++;
            $display("FAIL start_latency: got %0d want %0d", lat, DB + 3);
        end
        n_cmp++;
        if (nt < 100 || st[1] !== 2'd1) begin
            n_fail++;
            $display("FAIL wrap_run: ticks %0d state %0d want >=100 and 1", nt, st[1]);
        end
        n_cmp++;
        if (st[0] !== 2'd2) begin
            n_fail++;
            $display("FAIL halt_at_99: state %0d want 2", st[0]);
        end
    endtask

    task automatic test_reset_mid();
        int nclr = 0;
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got %b want 00000", i, obs(i));
            end
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (clr[0] || clr[1]) nclr++;
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL reset_mid_after[%0d] c=%0d: got %b want %b", i, c, obs(i), expv(i));
                end
            end
        end
        n_cmp++;
        if (nclr != 0) begin
            n_fail++;
            $display("FAIL reset_no_clr: got %0d clr cycles want 0", nclr);
        end
    endtask

    task automatic test_bounce();
        int ntrans = 0;
        logic [1:0] prev;
        for (int c = 0; c < 40; c++) begin
            ss = ((c / 3) % 2 == 0);
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== expv(i) || st[i] !== 2'd0) begin
                    n_fail++;
                    $display("FAIL bounce[%0d] c=%0d: got %b want %b", i, c, obs(i), expv(i));
                end
            end
        end
        prev = st[0];
        ss = 1'b1;
        for (int c = 0; c < 2 * PL; c++) begin
            if (c == PL) ss = 1'b0;
            @(negedge CLK);
            if (st[0] !== prev) ntrans++;
            prev = st[0];
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL bounce_stable[%0d] c=%0d: got %b want %b", i, c, obs(i), expv(i));
                end
            end
        end
        n_cmp++;
        if (ntrans != 1 || st[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL bounce_one_transition: got %0d to state %0d want 1 to 1", ntrans, st[0]);
        end
    endtask

    task automatic test_lap_pause_clear();
        int last = -1;
        int nclr[2] = '{0, 0};
        int clr_c[2] = '{-1, -1};
        int idle_c[2] = '{-1, -1};
        int ntick_pause = 0;
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < PL; c++) begin
                lr = (ph == 0 || ph == 4);
                ss = (ph == 2);
                @(negedge CLK);
                if (ph < 2 && tick[1]) begin
                    if (last >= 0) begin
                        n_cmp++;
                        if (cyc - last != TD) begin
                            n_fail++;
                            $display("FAIL lap_tick_period: got %0d want %0d", cyc - last, TD);
                        end
                    end
                    last = cyc;
                end
                if (ph == 3 && (tick[0] || tick[1])) ntick_pause++;
                for (int i = 0; i < 2; i++) begin
                    if (ph >= 4 && clr[i]) begin nclr[i]++; clr_c[i] = cyc; end
                    if (ph >= 4 && idle_c[i] < 0 && st[i] == 2'd0) idle_c[i] = cyc;
                    n_cmp++;
                    if (obs(i) !== expv(i)) begin
                        n_fail++;
                        $display("FAIL lap_pause_clear[%0d] ph=%0d c=%0d: got %b want %b", i, ph, c, obs(i), expv(i));
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (ph == 1) begin
                    n_cmp++;
                    if (st[i] !== 2'd3 || hold[i] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL lap_entry[%0d]: state %0d hold %b want 3 1", i, st[i], hold[i]);
                    end
                end
                if (ph == 3) begin
                    n_cmp++;
                    if (st[i] !== 2'd2 || hold[i] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL pause_entry[%0d]: state %0d hold %b want 2 0", i, st[i], hold[i]);
                    end
                end
            end
        end
        n_cmp++;
        if (ntick_pause != 0) begin
            n_fail++;
            $display("FAIL pause_no_tick: got %0d ticks want 0", ntick_pause);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (nclr[i] != 1 || clr_c[i] != idle_c[i] || st[i] !== 2'd0) begin
                n_fail++;
                $display("FAIL clear_pulse[%0d]: clr %0d at %0d idle at %0d state %0d want 1 pulse on first idle", i, nclr[i], clr_c[i], idle_c[i], st[i]);
            end
        end
    endtask

    task automatic test_max_stop();
        int run_c = -1;
        int first_tick = -1;
        int ntick_stop = 0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 2 * PL; c++) begin
                ss = (c < PL) && (ph == 0 || ph == 2);
                @(negedge CLK);
                if (ph == 0 && run_c < 0 && st[0] == 2'd1) begin
                    run_c = cyc;
                    force_max = 1'b1;
                end
                if (ph == 1) force_max = 1'b0;
                if (ph < 2 && tick[0]) ntick_stop++;
                if (ph < 2 && first_tick < 0 && tick[1]) first_tick = cyc;
                for (int i = 0; i < 2; i++) begin
                    n_cmp++;
                    if (obs(i) !== expv(i)) begin
                        n_fail++;
                        $display("FAIL max_stop[%0d] ph=%0d c=%0d: got %b want %b", i, ph, c, obs(i), expv(i));
                    end
                end
            end
        end
        n_cmp++;
        if (ntick_stop != 0) begin
            n_fail++;
            $display("FAIL max_no_tick: got %0d ticks want 0", ntick_stop);
        end
        n_cmp++;
        if (first_tick - run_c != TD) begin
            n_fail++;
            $display("FAIL first_tick_latency: got %0d want %0d", first_tick - run_c, TD);
        end
        n_cmp++;
        if (st[0] !== 2'd1 || st[1] !== 2'd2) begin
            n_fail++;
            $display("FAIL max_resume: states %0d/%0d want 1/2", st[0], st[1]);
        end
    endtask

    task automatic test_simultaneous();
        int nclr = 0;
        for (int c = 0; c < 2 * PL; c++) begin
            ss = (c < PL);
            lr = (c < PL);
            @(negedge CLK);
            if (clr[0] || clr[1]) nclr++;
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL simultaneous[%0d] c=%0d: got %b want %b", i, c, obs(i), expv(i));
                end
            end
        end
        n_cmp++;
        if (st[0] !== 2'd2 || hold[0] !== 1'b0 || st[1] !== 2'd1 || nclr != 0) begin
            n_fail++;
            $display("FAIL ss_priority: states %0d/%0d hold %b clr %0d want 2/1 0 0", st[0], st[1], hold[0], nclr);
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            len = $urandom_range(1, 14);
            ss = $urandom_range(0, 1);
            lr = $urandom_range(0, 1);
            force_max = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < len; c++) begin
                @(negedge CLK);
                for (int i = 0; i < 2; i++) begin
                    n_cmp++;
                    if (obs(i) !== expv(i)) begin
                        n_fail++;
                        $display("FAIL random[%0d] seg=%0d c=%0d: got %b want %b", i, seg, c, obs(i), expv(i));
                    end
                end
            end
        end
        ss = 1'b0;
        lr = 1'b0;
        force_max = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_run();
        test_reset_mid();
        test_bounce();
        test_lap_pause_clear();
        test_max_stop();
        test_simultaneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
